// File: rtl/count_strobe_driver.sv
// Issues spaced single-cycle count strobes until the downstream counter answers with time_out,
// then pulses done (with error if the strobe budget ran out first) and reports the strobe tally.
module count_strobe_driver #(
    parameter int GAP_W       = 8,
    parameter int CNT_W       = 5,
    parameter int MAX_STROBES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    input  logic             time_out,
    output logic             count,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] strobes
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STROBE = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STROBES);

    logic [1:0]       state;
    logic [GAP_W-1:0] gap_reg;
    logic [GAP_W-1:0] gap_cnt;
    logic [1:0]       wait_cnt;
    logic [CNT_W-1:0] strobes_nxt;

    // Saturating tally so a long run can never wrap the counter.
    assign strobes_nxt = (strobes == MAX_C) ? MAX_C : strobes + 1'b1;

    // The strobe is gated by the answer so nothing is issued once the counter has replied.
    assign count = (state == S_STROBE) && !time_out;
    assign busy  = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            gap_reg  <= '0;
            gap_cnt  <= '0;
            wait_cnt <= '0;
            strobes  <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (state != S_IDLE && abort) begin
                state <= S_IDLE;
            end else if (state != S_IDLE && time_out) begin
                state <= S_IDLE;
                done  <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            gap_reg <= gap;
                            strobes <= '0;
                            state   <= S_STROBE;
                        end
                    end
                    S_STROBE: begin
                        strobes <= strobes_nxt;
                        if (strobes_nxt == MAX_C) begin
                            wait_cnt <= 2'd2;
                            state    <= S_WAIT;
                        end else if (gap_reg != '0) begin
                            gap_cnt <= gap_reg;
                            state   <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        gap_cnt <= gap_cnt - 1'b1;
                        if (gap_cnt == GAP_W'(1)) begin
                            state <= S_STROBE;
                        end
                    end
                    S_WAIT: begin
                        wait_cnt <= wait_cnt - 2'd1;
                        if (wait_cnt == 2'd1) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_strobe_driver.sv
// Randomized and directed checks of count_strobe_driver against a run-schedule model.
module tb_count_strobe_driver;

    localparam int MAX = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] gap;
    logic       abort;
    logic       time_out;
    logic       count;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] strobes;

    count_strobe_driver #(.GAP_W(8), .CNT_W(5), .MAX_STROBES(MAX)) dut (
        .clk(clk), .reset(reset), .start(start), .gap(gap), .abort(abort),
        .time_out(time_out), .count(count), .busy(busy), .done(done),
        .error(error), .strobes(strobes)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: a run is described by its cycle index t (1 = first busy cycle) and gap g.
    bit m_run;
    int m_t;
    int m_g;
    int m_last;
    bit m_done;
    bit m_err;

    function automatic int issued_before(int t, int g);
        int n;
        if (t <= 1) return 0;
        n = (t - 2) / (g + 1) + 1;
        return (n > MAX) ? MAX : n;
    endfunction

    function automatic bit is_strobe(int t, int g);
        return ((t - 1) % (g + 1) == 0) && ((t - 1) / (g + 1) < MAX);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        int exp_strobes;
        exp_strobes = m_run ? issued_before(m_t, m_g) : m_last;
        chk("busy", int'(busy), int'(m_run));
        chk("count", int'(count), int'(m_run && is_strobe(m_t, m_g) && !time_out));
        chk("strobes", int'(strobes), exp_strobes);
        chk("done", int'(done), int'(m_done));
        chk("error", int'(error), int'(m_err));
    endtask

    task automatic model_reset();
        m_run = 0; m_t = 0; m_g = 0; m_last = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_update(input bit s, input int g, input bit ab, input bit to);
        int t_last;
        m_done = 0;
        m_err  = 0;
        if (m_run) begin
            t_last = (MAX - 1) * (m_g + 1) + 1;
            if (ab) begin
                m_run  = 0;
                m_last = issued_before(m_t, m_g);
            end else if (to) begin
                m_run  = 0;
                m_done = 1;
                m_last = issued_before(m_t, m_g);
            end else if (m_t == t_last + 2) begin
                m_run  = 0;
                m_done = 1;
                m_err  = 1;
                m_last = MAX;
            end else begin
                m_t++;
            end
        end else if (s) begin
            m_run = 1;
            m_t   = 1;
            m_g   = g;
        end
    endtask

    // Drive one cycle's inputs, check outputs, then advance across the clock edge.
    task automatic step(input bit s, input int g, input bit ab, input bit to);
        start    = s;
        gap      = g[7:0];
        abort    = ab;
        time_out = to;
        #1 compare();
        @(posedge clk);
        #1;
        model_update(s, g, ab, to);
        cyc++;
    endtask

    initial begin
        int p;
        bit s, ab, to;
        int g;

        reset = 1'b1; start = 0; gap = 0; abort = 0; time_out = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_strobes", int'(strobes), 0);
        reset = 1'b0;
        step(0, 0, 0, 0);

        // Back-to-back strobes, answer in cycle 12.
        step(1, 0, 0, 0);
        for (int k = 1; k <= 11; k++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("b2b_done", int'(done), 1);
        chk("b2b_error", int'(error), 0);
        chk("b2b_strobes", int'(strobes), 11);
        chk("b2b_busy", int'(busy), 0);
        step(0, 0, 0, 0);

        // Budget exhausted, then restart in the done cycle with a new gap.
        step(1, 0, 0, 0);
        for (int k = 1; k <= 18; k++) step(0, 0, 0, 0);
        chk("budget_done", int'(done), 1);
        chk("budget_error", int'(error), 1);
        chk("budget_strobes", int'(strobes), 16);
        chk("budget_busy", int'(busy), 0);
        step(1, 3, 0, 0);
        chk("restart_busy", int'(busy), 1);
        chk("restart_strobes", int'(strobes), 0);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0);
        chk("restart_spacing", int'(strobes), 2);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Spaced strobes with gap=2; gap input changes mid-run must not matter.
        step(1, 2, 0, 0);
        for (int k = 1; k <= 31; k++) step(0, 7, 0, 0);
        step(0, 7, 0, 1);
        chk("spaced_done", int'(done), 1);
        chk("spaced_strobes", int'(strobes), 11);
        step(0, 0, 0, 0);

        // Abort in cycle 6 with a start attempted while busy.
        step(1, 1, 0, 0);
        for (int k = 1; k <= 5; k++) step((k == 3), (k == 3) ? 5 : 1, 0, 0);
        step(0, 1, 1, 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_strobes", int'(strobes), 3);
        step(0, 0, 0, 0);

        // Asynchronous reset mid-run.
        step(1, 0, 0, 0);
        for (int k = 1; k <= 4; k++) step(0, 0, 0, 0);
        start = 0; abort = 0; time_out = 0;
        #2;
        chk("prereset_strobes", int'(strobes), 4);
        reset = 1'b1;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_strobes", int'(strobes), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Randomized traffic with varying answer probability.
        for (int blk = 0; blk < 6; blk++) begin
            case (blk % 3)
                0: p = 0;
                1: p = 30;
                default: p = 8;
            endcase
            for (int i = 0; i < 500; i++) begin
                s  = ($urandom % 6 == 0);
                g  = ($urandom % 16 == 0) ? int'($urandom % 20) : int'($urandom % 4);
                ab = ($urandom % 50 == 0);
                to = (p == 0) ? 1'b0 : ($urandom % p == 0);
                step(s, g, ab, to);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
